i2c_target: RTL and testbench

- Clock-synchronous I2C target (slave) engine; the bus-side counterpart of the team's I2C master.
- Oversamples the open-drain SCL/SDA inputs with clk and detects START, repeated START and STOP.
- Matches a fixed 7-bit address, receives write bytes and transmits read bytes through a byte-level handshake to local logic.
- Stretches SCL while waiting for transmit data.

---
 rtl/i2c_target.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_i2c_target.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target engine: oversampled SCL/SDA, fixed 7-bit address, byte-level
// receive strobe and transmit request/acknowledge with SCL stretching.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         PER_HD_DATA = 3,
  parameter int         PER_LD_SIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  input  logic       sda,
  output logic       scl_out,
  output logic       sda_out,
  output logic [7:0] rx_dat,
  output logic       rx_vld,
  output logic       rx_first,
  input  logic       ack_en,
  input  logic [7:0] tx_dat,
  output logic       tx_req,
  input  logic       tx_ack,
  output logic       busy,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_AACK, ST_WR, ST_WACK, ST_TXW, ST_RD, ST_RACK
  } state_t;

  localparam logic [PER_LD_SIZE-1:0] HD  = PER_LD_SIZE'(PER_HD_DATA);
  localparam logic [PER_LD_SIZE-1:0] ONE = PER_LD_SIZE'(1);

  // Bus sampling
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic s_scl, s_sda, p_scl, p_sda;
  logic start, stop, rise, fall;

  assign s_scl = scl_sync[SYNC_STAGES-1];
  assign s_sda = sda_sync[SYNC_STAGES-1];
  assign start = s_scl & p_sda & ~s_sda;
  assign stop  = s_scl & ~p_sda & s_sda;
  assign rise  = ~p_scl & s_scl;
  assign fall  = p_scl & ~s_scl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      p_scl    <= 1'b1;
      p_sda    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      p_scl    <= s_scl;
      p_sda    <= s_sda;
    end
  end

  // Engine state
  state_t                 state, state_d;
  logic [2:0]             bit_cnt, bit_cnt_d;
  logic [6:0]             shreg, shreg_d;
  logic                   rw, rw_d;
  logic                   first_arm, first_arm_d;
  logic                   acked, acked_d;
  logic                   ack_bit, ack_bit_d;
  logic [7:0]             tx_byte, tx_byte_d;
  logic                   tx_loaded, tx_loaded_d;
  logic [PER_LD_SIZE-1:0] hd_cnt, hd_cnt_d;
  logic                   hd_act, hd_act_d;
  logic                   sda_pend, sda_pend_d;
  logic                   sda_out_d, scl_out_d, tx_req_d, busy_d;
  logic                   rx_vld_d, rx_first_d, stop_det_d;
  logic [7:0]             rx_dat_d;
  logic                   sched, sched_val;

  // Transmit handshake: tx_req is a level held while SCL is stretched; a
  // tx_ack pulse seen while tx_req=1 transfers tx_dat, any other tx_ack is ignored.
  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    rw_d        = rw;
    first_arm_d = first_arm;
    acked_d     = acked;
    ack_bit_d   = ack_bit;
    tx_byte_d   = tx_byte;
    tx_loaded_d = tx_loaded;
    hd_cnt_d    = hd_cnt;
    hd_act_d    = hd_act;
    sda_pend_d  = sda_pend;
    sda_out_d   = sda_out;
    scl_out_d   = scl_out;
    tx_req_d    = tx_req;
    busy_d      = busy;
    rx_dat_d    = rx_dat;
    rx_vld_d    = 1'b0;
    rx_first_d  = 1'b0;
    stop_det_d  = 1'b0;
    sched       = 1'b0;
    sched_val   = 1'b1;

    // A scheduled SDA level lands after the hold time, and only with SCL low.
    if (hd_act && !s_scl) begin
      if (hd_cnt <= ONE) begin
        sda_out_d = sda_pend;
        hd_act_d  = 1'b0;
      end else begin
        hd_cnt_d = hd_cnt - ONE;
      end
    end

    case (state)
      ST_IDLE: ;
      ST_ADDR: begin
        if (rise) begin
          shreg_d   = {shreg[5:0], s_sda};
          bit_cnt_d = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            rw_d = s_sda;
            if (shreg == ADDR) begin
              state_d   = ST_AACK;
              ack_bit_d = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_AACK: begin
        if (fall) begin
          sched = 1'b1;
          if (!ack_bit) begin
            sched_val = 1'b0;
            busy_d    = 1'b1;
            ack_bit_d = 1'b1;
          end else if (rw) begin
            state_d     = ST_TXW;
            scl_out_d   = 1'b0;
            tx_req_d    = 1'b1;
            tx_loaded_d = 1'b0;
          end else begin
            state_d     = ST_WR;
            bit_cnt_d   = 3'd7;
            first_arm_d = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (rise) begin
          shreg_d   = {shreg[5:0], s_sda};
          bit_cnt_d = bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            rx_vld_d    = 1'b1;
            rx_dat_d    = {shreg, s_sda};
            rx_first_d  = first_arm;
            first_arm_d = 1'b0;
            state_d     = ST_WACK;
            ack_bit_d   = 1'b0;
          end
        end
      end
      ST_WACK: begin
        if (fall) begin
          if (!ack_bit) begin
            ack_bit_d = 1'b1;
            acked_d   = ack_en;
            if (ack_en) begin
              sched     = 1'b1;
              sched_val = 1'b0;
            end
          end else begin
            sched = 1'b1;
            if (acked) begin
              state_d   = ST_WR;
              bit_cnt_d = 3'd7;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_TXW: begin
        if (tx_ack && tx_req) begin
          tx_byte_d   = tx_dat;
          tx_req_d    = 1'b0;
          sched       = 1'b1;
          sched_val   = tx_dat[7];
          tx_loaded_d = 1'b1;
        end else if (tx_loaded && !hd_act) begin
          // MSB is already on sda_out, so SCL is let go one cycle after it settles.
          scl_out_d   = 1'b1;
          tx_loaded_d = 1'b0;
          state_d     = ST_RD;
          bit_cnt_d   = 3'd7;
        end
      end
      ST_RD: begin
        if (fall) begin
          sched = 1'b1;
          if (bit_cnt == 3'd0) begin
            state_d   = ST_RACK;
            ack_bit_d = 1'b0;
          end else begin
            sched_val = tx_byte[bit_cnt - 3'd1];
            bit_cnt_d = bit_cnt - 3'd1;
          end
        end
      end
      ST_RACK: begin
        if (rise) begin
          if (s_sda) state_d = ST_IDLE;
          else       ack_bit_d = 1'b1;
        end else if (fall && ack_bit) begin
          state_d     = ST_TXW;
          scl_out_d   = 1'b0;
          tx_req_d    = 1'b1;
          tx_loaded_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (sched) begin
      hd_act_d   = 1'b1;
      hd_cnt_d   = HD;
      sda_pend_d = sched_val;
    end

    // START/STOP win over everything and release both lines at once.
    if (start) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd7;
      sda_out_d   = 1'b1;
      scl_out_d   = 1'b1;
      tx_req_d    = 1'b0;
      tx_loaded_d = 1'b0;
      hd_act_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop) begin
      state_d     = ST_IDLE;
      sda_out_d   = 1'b1;
      scl_out_d   = 1'b1;
      tx_req_d    = 1'b0;
      tx_loaded_d = 1'b0;
      hd_act_d    = 1'b0;
      stop_det_d  = busy;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 3'd7;
      shreg     <= '0;
      rw        <= 1'b0;
      first_arm <= 1'b0;
      acked     <= 1'b0;
      ack_bit   <= 1'b0;
      tx_byte   <= '0;
      tx_loaded <= 1'b0;
      hd_cnt    <= '0;
      hd_act    <= 1'b0;
      sda_pend  <= 1'b1;
      sda_out   <= 1'b1;
      scl_out   <= 1'b1;
      tx_req    <= 1'b0;
      busy      <= 1'b0;
      rx_dat    <= '0;
      rx_vld    <= 1'b0;
      rx_first  <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      state     <= state_d;
      bit_cnt   <= bit_cnt_d;
      shreg     <= shreg_d;
      rw        <= rw_d;
      first_arm <= first_arm_d;
      acked     <= acked_d;
      ack_bit   <= ack_bit_d;
      tx_byte   <= tx_byte_d;
      tx_loaded <= tx_loaded_d;
      hd_cnt    <= hd_cnt_d;
      hd_act    <= hd_act_d;
      sda_pend  <= sda_pend_d;
      sda_out   <= sda_out_d;
      scl_out   <= scl_out_d;
      tx_req    <= tx_req_d;
      busy      <= busy_d;
      rx_dat    <= rx_dat_d;
      rx_vld    <= rx_vld_d;
      rx_first  <= rx_first_d;
      stop_det  <= stop_det_d;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level bus master, a transmit-data
// responder and a receive scoreboard, checked with immediate assertions.
module tb_i2c_target;

  localparam int Q = 10;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_bus, sda_bus;
  logic       scl_out, sda_out, rx_vld, rx_first, tx_req, busy, stop_det;
  logic [7:0] rx_dat;
  logic       ack_en = 1'b1;
  logic [7:0] tx_dat = 8'h00;
  logic       tx_ack = 1'b0;

  assign scl_bus = scl_m & scl_out;
  assign sda_bus = sda_m & sda_out;

  i2c_target dut (
    .clk(clk), .rst(rst), .scl(scl_bus), .sda(sda_bus),
    .scl_out(scl_out), .sda_out(sda_out),
    .rx_dat(rx_dat), .rx_vld(rx_vld), .rx_first(rx_first), .ack_en(ack_en),
    .tx_dat(tx_dat), .tx_req(tx_req), .tx_ack(tx_ack),
    .busy(busy), .stop_det(stop_det)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];
  int         stretch_q[$];
  int         stop_cnt = 0;
  bit         sda_low_seen = 1'b0;
  logic [8:0] exp_e;
  int         low_cnt;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard for received bytes, plus stop and SDA-drive monitors
  always @(negedge clk) begin
    if (rx_vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL rx_unexpected: observed %0h expected none", {rx_first, rx_dat});
      end else begin
        exp_e = exp_q.pop_front();
        assert ({rx_first, rx_dat} === exp_e) else begin
          errors++;
          $error("FAIL rx_byte: observed %0h expected %0h", {rx_first, rx_dat}, exp_e);
        end
      end
    end
    if (stop_det) stop_cnt++;
    if (!sda_out) sda_low_seen = 1'b1;
  end

  // Transmit responder: answers each request 20 cycles late
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req && tx_q.size() > 0) begin
        low_cnt = 0;
        repeat (20) begin
          @(negedge clk);
          if (!scl_bus) low_cnt++;
        end
        stretch_q.push_back(low_cnt);
        tx_dat = tx_q.pop_front();
        tx_ack = 1'b1;
        @(negedge clk);
        tx_ack = 1'b0;
      end
    end
  end

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n;
    n = 0;
    while (scl_bus !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $error("FAIL scl_timeout: observed 0 expected 1");
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; wait_clks(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clks(Q);
    b = sda_bus; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack_bit);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_bit);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(nack);
  endtask

  logic       a;
  logic [7:0] d;
  int         s0;

  initial begin
    // Reset values
    rst = 1'b1;
    wait_clks(3);
    check("rst_scl_out", 32'(scl_out), 1);
    check("rst_sda_out", 32'(sda_out), 1);
    check("rst_rx_vld", 32'(rx_vld), 0);
    check("rst_rx_first", 32'(rx_first), 0);
    check("rst_tx_req", 32'(tx_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stop_det", 32'(stop_det), 0);
    check("rst_rx_dat", 32'(rx_dat), 0);
    rst = 1'b0;
    wait_clks(5);

    // Write of two data bytes
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("wr_addr_ack", 32'(a), 0);
    check("wr_busy", 32'(busy), 1);
    write_byte(8'h12, a); check("wr_b1_ack", 32'(a), 0);
    write_byte(8'h34, a); check("wr_b2_ack", 32'(a), 0);
    check("wr_rx_dat", 32'(rx_dat), 'h34);
    i2c_stop();
    wait_clks(5);
    check("wr_busy_end", 32'(busy), 0);
    check("wr_stop_det", stop_cnt - s0, 1);
    check("wr_rx_all", exp_q.size(), 0);

    // Address mismatch
    sda_low_seen = 1'b0;
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA2, a); check("mm_nack", 32'(a), 1);
    check("mm_busy", 32'(busy), 0);
    i2c_stop();
    wait_clks(5);
    check("mm_sda_never_low", 32'(sda_low_seen), 0);
    check("mm_no_stop_det", stop_cnt - s0, 0);

    // Read of two bytes with stretching
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hC3);
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA1, a); check("rd_addr_ack", 32'(a), 0);
    read_byte(1'b0, d); check("rd_b1", 32'(d), 'h5A);
    read_byte(1'b1, d); check("rd_b2", 32'(d), 'hC3);
    wait_clks(30);
    check("rd_sda_released", 32'(sda_out), 1);
    check("rd_tx_req_low", 32'(tx_req), 0);
    check("rd_busy", 32'(busy), 1);
    check("rd_stretch_cnt", stretch_q.size(), 2);
    while (stretch_q.size() > 0) check("rd_stretch_len", stretch_q.pop_front(), 20);
    i2c_stop();
    wait_clks(5);
    check("rd_stop_det", stop_cnt - s0, 1);
    check("rd_busy_end", 32'(busy), 0);

    // NACK on the second write byte, then re-address without STOP
    exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("nw_addr_ack", 32'(a), 0);
    ack_en = 1'b1;
    write_byte(8'h11, a); check("nw_b1_ack", 32'(a), 0);
    ack_en = 1'b0;
    write_byte(8'h22, a); check("nw_b2_nack", 32'(a), 1);
    ack_en = 1'b1;
    check("nw_busy_held", 32'(busy), 1);
    check("nw_rx_all", exp_q.size(), 0);
    i2c_start();
    write_byte(8'hA0, a); check("nw_readdr_ack", 32'(a), 0);
    i2c_stop();
    wait_clks(5);
    check("nw_stop_det", stop_cnt - s0, 1);

    // Repeated START from write into read
    exp_q.push_back({1'b1, 8'h07});
    tx_q.push_back(8'h99);
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("sr_waddr_ack", 32'(a), 0);
    write_byte(8'h07, a); check("sr_b_ack", 32'(a), 0);
    check("sr_rx_dat", 32'(rx_dat), 'h07);
    i2c_start();
    write_byte(8'hA1, a); check("sr_raddr_ack", 32'(a), 0);
    read_byte(1'b1, d); check("sr_rd", 32'(d), 'h99);
    i2c_stop();
    wait_clks(5);
    check("sr_stop_det", stop_cnt - s0, 1);
    check("sr_stretch_len", stretch_q.pop_front(), 20);

    // Reset while driving a 0 data bit
    tx_q.push_back(8'h5A);
    i2c_start();
    write_byte(8'hA1, a); check("rr_addr_ack", 32'(a), 0);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clks(Q);
    check("rr_sda_driven", 32'(sda_out), 0);
    rst = 1'b1;
    #1;
    check("rr_sda_rel", 32'(sda_out), 1);
    check("rr_scl_rel", 32'(scl_out), 1);
    check("rr_tx_req", 32'(tx_req), 0);
    check("rr_busy", 32'(busy), 0);
    wait_clks(3);
    rst = 1'b0;
    check("rr_stretch_len", stretch_q.pop_front(), 20);
    wait_clks(5);
    s0 = stop_cnt;
    i2c_start();
    write_byte(8'hA0, a); check("rr_readdr_ack", 32'(a), 0);
    check("rr_busy_again", 32'(busy), 1);
    i2c_stop();
    wait_clks(5);
    check("rr_stop_det", stop_cnt - s0, 1);

    check("final_rx_all", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
